m31_poseidon2_result_collector: RTL and testbench

//   Output-side companion to m31_poseidon2_top: tracks permutations issued into the fixed-latency,
//   non-stalling core, captures each result on the exact cycle it emerges on state_o, and buffers
//   the digest words with their tag in a small FIFO behind a ready/valid interface.

---
 rtl/m31_poseidon2_result_collector_if.sv | 31 +++
 rtl/m31_poseidon2_result_collector.sv | 122 ++++++++++++
 tb/tb_m31_poseidon2_result_collector.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/m31_poseidon2_result_collector_if.sv
// Issue/result bundle between upstream, the Poseidon2 core output and the result consumer.
// slave = collector side; master = the driver/consumer side.
interface m31_poseidon2_result_collector_if #(
  parameter int WIDTH      = 16,
  parameter int OUT_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 8
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic                        issue_valid_i;
  logic [TAG_W-1:0]            issue_tag_i;
  logic                        issue_ready_o;
  logic [WIDTH-1:0][30:0]      core_state_i;
  logic                        res_valid_o;
  logic                        res_ready_i;
  logic [OUT_WIDTH-1:0][30:0]  res_data_o;
  logic [TAG_W-1:0]            res_tag_o;
  logic [CNT_W-1:0]            inflight_o;
  logic                        overflow_o;

  modport slave (
    input  issue_valid_i, issue_tag_i, core_state_i, res_ready_i,
    output issue_ready_o, res_valid_o, res_data_o, res_tag_o, inflight_o, overflow_o
  );

  modport master (
    output issue_valid_i, issue_tag_i, core_state_i, res_ready_i,
    input  issue_ready_o, res_valid_o, res_data_o, res_tag_o, inflight_o, overflow_o
  );
endinterface

// File: rtl/m31_poseidon2_result_collector.sv
// Captures fixed-latency Poseidon2 core results into a FWFT FIFO; empty-FIFO latency is LATENCY cycles.
// Issue is credit-gated on inflight+occupancy so every in-flight result has a slot; consumer backpressure only stalls issue.
module m31_poseidon2_result_collector #(
  parameter int WIDTH      = 16,
  parameter int OUT_WIDTH  = 8,
  parameter int LATENCY    = 287,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 8
) (
  input logic clk,
  input logic rst,
  m31_poseidon2_result_collector_if.slave bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(FIFO_DEPTH - 1);

  logic [LATENCY-1:0]          r_vld_dl;
  logic [TAG_W-1:0]            r_tag_dl [LATENCY];
  logic [OUT_WIDTH-1:0][30:0]  r_mem_dat [FIFO_DEPTH];
  logic [TAG_W-1:0]            r_mem_tag [FIFO_DEPTH];
  logic [PTR_W-1:0]            r_wr_ptr;
  logic [PTR_W-1:0]            r_rd_ptr;
  logic [CNT_W-1:0]            r_count;
  logic [CNT_W-1:0]            r_inflight;
  logic                        r_overflow;

  logic [CNT_W:0]              w_credit_used;
  logic                        w_issue_ready;
  logic                        w_fire;
  logic                        w_capture;
  logic                        w_not_empty;
  logic                        w_full;
  logic                        w_pop;
  logic                        w_push;
  logic                        w_unused_state;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  // Credit counts results still in the core plus results already buffered.
  assign w_credit_used = {1'b0, r_inflight} + {1'b0, r_count};
  assign w_issue_ready = w_credit_used < {1'b0, DEPTH_C};
  assign w_fire        = bus.issue_valid_i && w_issue_ready;
  assign w_capture     = r_vld_dl[LATENCY-1];

  assign w_not_empty   = (r_count != '0);
  assign w_full        = (r_count == DEPTH_C);
  assign w_pop         = w_not_empty && bus.res_ready_i;
  assign w_push        = w_capture && (!w_full || w_pop);

  assign w_unused_state = ^bus.core_state_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_dl <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_tag_dl[i] <= '0;
      end
    end else begin
      r_vld_dl[0] <= w_fire;
      r_tag_dl[0] <= w_fire ? bus.issue_tag_i : '0;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld_dl[i] <= r_vld_dl[i-1];
        r_tag_dl[i] <= r_tag_dl[i-1];
      end
    end
  end

  // Storage is not reset; the empty mask on the outputs hides stale entries.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_dat[r_wr_ptr] <= bus.core_state_i[OUT_WIDTH-1:0];
      r_mem_tag[r_wr_ptr] <= r_tag_dl[LATENCY-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_inflight <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ptr_next(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_next(r_rd_ptr);
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      case ({w_fire, w_capture})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase

      // Only reachable if the credit check is broken; sticky until reset.
      if (w_capture && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign bus.issue_ready_o = w_issue_ready;
  assign bus.res_valid_o   = w_not_empty;
  assign bus.res_data_o    = w_not_empty ? r_mem_dat[r_rd_ptr] : '0;
  assign bus.res_tag_o     = w_not_empty ? r_mem_tag[r_rd_ptr] : '0;
  assign bus.inflight_o    = r_inflight;
  assign bus.overflow_o    = r_overflow;

endmodule

// File: tb/tb_m31_poseidon2_result_collector.sv
// Directed bench for the result collector; a behavioural fixed-latency core feeds core_state_i.
module tb_m31_poseidon2_result_collector;

  localparam int LAT = 287;
  typedef logic [15:0][30:0] state_t;

  logic   clk;
  logic   rst;
  int     checks;
  int     failures;
  state_t perm_out;
  state_t core_pipe [LAT];
  state_t r1;
  state_t r2;
  state_t rx;
  state_t junk;
  int     n;
  int     seen_valid;
  int     seen_x;

  m31_poseidon2_result_collector_if #(.WIDTH(16), .OUT_WIDTH(8), .FIFO_DEPTH(4), .TAG_W(8)) bus ();

  m31_poseidon2_result_collector #(
    .WIDTH(16), .OUT_WIDTH(8), .LATENCY(LAT), .FIFO_DEPTH(4), .TAG_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the core: whatever result the bench attaches to a cycle emerges LAT edges later.
  always @(posedge clk) begin
    core_pipe[0] <= perm_out;
    for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign bus.core_state_i = core_pipe[LAT-1];

  function automatic state_t mk(input logic [30:0] base);
    state_t s;
    for (int i = 0; i < 16; i++) s[i] = base + 31'(i);
    return s;
  endfunction

  function automatic state_t perm_of(input logic [7:0] tag);
    return mk(31'h20000000 + {11'h0, tag, 12'h0});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    junk     = mk(31'h2BADBEEF);
    perm_out = junk;
    rst      = 1'b1;
    bus.issue_valid_i = 1'b0;
    bus.issue_tag_i   = 8'h00;
    bus.res_ready_i   = 1'b0;
    repeat (3) tick();

    chk("rst_res_valid", 64'(bus.res_valid_o), 64'd0);
    chk("rst_res_data",  64'(bus.res_data_o[0] | bus.res_data_o[7]), 64'd0);
    chk("rst_res_tag",   64'(bus.res_tag_o), 64'd0);
    chk("rst_inflight",  64'(bus.inflight_o), 64'd0);
    chk("rst_overflow",  64'(bus.overflow_o), 64'd0);
    chk("rst_ready",     64'(bus.issue_ready_o), 64'd1);
    rst = 1'b0;
    tick();

    // 1: single issue, exact latency, consumer always ready
    r1 = mk(31'h11110000);
    r1[0] = 31'h34ecac18; r1[1] = 31'h41e09387; r1[2] = 31'h62a4f1ff; r1[7] = 31'h7f092d69;
    bus.res_ready_i   = 1'b1;
    bus.issue_valid_i = 1'b1;
    bus.issue_tag_i   = 8'h05;
    perm_out          = r1;
    tick();
    bus.issue_valid_i = 1'b0;
    perm_out          = junk;
    chk("t1_inflight_up", 64'(bus.inflight_o), 64'd1);
    n = 0;
    while (!bus.res_valid_o && n < 2 * LAT) begin
      tick();
      n++;
    end
    chk("t1_latency", 64'(n), 64'(LAT));
    chk("t1_tag",   64'(bus.res_tag_o), 64'h05);
    chk("t1_data0", 64'(bus.res_data_o[0]), 64'h34ecac18);
    chk("t1_data1", 64'(bus.res_data_o[1]), 64'h41e09387);
    chk("t1_data2", 64'(bus.res_data_o[2]), 64'h62a4f1ff);
    chk("t1_data7", 64'(bus.res_data_o[7]), 64'h7f092d69);
    chk("t1_inflight_down", 64'(bus.inflight_o), 64'd0);
    tick();
    chk("t1_popped", 64'(bus.res_valid_o), 64'd0);

    // 2: second vector, consumer stalled so the entry is held
    r2 = mk(31'h22220000);
    r2[0] = 31'h43074f9a; r2[7] = 31'h256350ae;
    bus.res_ready_i   = 1'b0;
    bus.issue_valid_i = 1'b1;
    bus.issue_tag_i   = 8'hA2;
    perm_out          = r2;
    tick();
    bus.issue_valid_i = 1'b0;
    perm_out          = junk;
    repeat (LAT - 1) tick();
    chk("t2_not_early", 64'(bus.res_valid_o), 64'd0);
    tick();
    chk("t2_valid", 64'(bus.res_valid_o), 64'd1);
    chk("t2_data0", 64'(bus.res_data_o[0]), 64'h43074f9a);
    chk("t2_data7", 64'(bus.res_data_o[7]), 64'h256350ae);
    chk("t2_tag",   64'(bus.res_tag_o), 64'hA2);
    bus.res_ready_i = 1'b1;
    tick();
    bus.res_ready_i = 1'b0;
    chk("t2_popped", 64'(bus.res_valid_o), 64'd0);

    // 3: valid held with tags 0..7 and no consumer; credit caps acceptance at 4
    bus.issue_valid_i = 1'b1;
    for (int t = 0; t < 8; t++) begin
      bus.issue_tag_i = 8'(t);
      perm_out        = perm_of(8'(t));
      chk("t3_ready", 64'(bus.issue_ready_o), (t < 4) ? 64'd1 : 64'd0);
      tick();
    end
    bus.issue_valid_i = 1'b0;
    perm_out          = junk;
    chk("t3_inflight_peak", 64'(bus.inflight_o), 64'd4);
    n = 0;
    while (bus.inflight_o != 0 && n < 2 * LAT) begin
      tick();
      n++;
    end
    chk("t3_inflight_drained", 64'(bus.inflight_o), 64'd0);
    repeat (8) tick();
    rx = perm_of(8'h00);
    chk("t3_full_valid", 64'(bus.res_valid_o), 64'd1);
    chk("t3_full_ready", 64'(bus.issue_ready_o), 64'd0);
    chk("t3_overflow",   64'(bus.overflow_o), 64'd0);
    chk("t3_head_tag",   64'(bus.res_tag_o), 64'h00);
    chk("t3_head_data0", 64'(bus.res_data_o[0]), 64'(rx[0]));

    // 4: drain while issuing; each pop frees a credit used on the next edge
    bus.res_ready_i   = 1'b1;
    bus.issue_valid_i = 1'b1;
    for (int j = 0; j < 5; j++) begin
      if (j < 4) chk("t4_head_tag", 64'(bus.res_tag_o), 64'(j));
      bus.issue_tag_i = 8'(8'h3F + j);
      perm_out        = perm_of(8'(8'h3F + j));
      tick();
      chk("t4_inflight", 64'(bus.inflight_o), 64'(j));
      chk("t4_ready", 64'(bus.issue_ready_o), (j < 4) ? 64'd1 : 64'd0);
    end
    bus.issue_valid_i = 1'b0;
    bus.res_ready_i   = 1'b0;
    perm_out          = junk;

    // 5: capture and pop on the same edge with credit exhausted
    n = 0;
    while (bus.inflight_o != 0 && n < 2 * LAT) begin
      tick();
      n++;
    end
    chk("t5_head_40", 64'(bus.res_tag_o), 64'h40);
    chk("t5_full_ready", 64'(bus.issue_ready_o), 64'd0);
    bus.res_ready_i = 1'b1;
    tick();
    bus.res_ready_i = 1'b0;
    chk("t5_head_41", 64'(bus.res_tag_o), 64'h41);
    chk("t5_credit_back", 64'(bus.issue_ready_o), 64'd1);
    bus.issue_valid_i = 1'b1;
    bus.issue_tag_i   = 8'h50;
    perm_out          = perm_of(8'h50);
    tick();
    bus.issue_valid_i = 1'b0;
    perm_out          = junk;
    chk("t5_no_credit", 64'(bus.issue_ready_o), 64'd0);
    repeat (LAT - 1) tick();
    chk("t5_inflight_pre", 64'(bus.inflight_o), 64'd1);
    bus.res_ready_i = 1'b1;
    tick();
    chk("t5_head_42", 64'(bus.res_tag_o), 64'h42);
    chk("t5_inflight_post", 64'(bus.inflight_o), 64'd0);
    chk("t5_overflow", 64'(bus.overflow_o), 64'd0);
    tick();
    chk("t5_head_43", 64'(bus.res_tag_o), 64'h43);
    tick();
    rx = perm_of(8'h50);
    chk("t5_head_50", 64'(bus.res_tag_o), 64'h50);
    chk("t5_data0_50", 64'(bus.res_data_o[0]), 64'(rx[0]));
    tick();
    chk("t5_empty", 64'(bus.res_valid_o), 64'd0);
    bus.res_ready_i = 1'b0;

    // 6: reset mid-flight discards the pending result
    bus.issue_valid_i = 1'b1;
    bus.issue_tag_i   = 8'h11;
    perm_out          = perm_of(8'h11);
    tick();
    bus.issue_valid_i = 1'b0;
    perm_out          = junk;
    repeat (99) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    seen_valid = 0;
    seen_x     = 0;
    for (int i = 0; i < 2 * LAT; i++) begin
      tick();
      if (bus.res_valid_o !== 1'b0) seen_valid++;
      if ($isunknown({bus.issue_ready_o, bus.res_valid_o, bus.res_data_o, bus.res_tag_o,
                      bus.inflight_o, bus.overflow_o})) seen_x++;
    end
    chk("t6_valid_never", 64'(seen_valid), 64'd0);
    chk("t6_no_x", 64'(seen_x), 64'd0);
    chk("t6_inflight", 64'(bus.inflight_o), 64'd0);
    chk("t6_ready", 64'(bus.issue_ready_o), 64'd1);
    chk("t6_overflow", 64'(bus.overflow_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
